// File: rtl/timer_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the timer controller.
// Pure definitions: no latency, no flow control.
package timer_ctrl_pkg;

    localparam logic [1:0] OP_LOAD_PERIOD   = 2'd0;
    localparam logic [1:0] OP_LOAD_PRESCALE = 2'd1;
    localparam logic [1:0] OP_START         = 2'd2;
    localparam logic [1:0] OP_STOP          = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic state_is_busy(input state_t st);
        return (st == ST_ARM) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle ticks every prescale+1 enabled cycles; tick is combinational.
// clear wins over enable; no backpressure.
module tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    always_comb begin
        tick      = enable && (pre_cnt_q == prescale);
        pre_cnt_d = pre_cnt_q;
        if (clear) begin
            pre_cnt_d = '0;
        end else if (enable) begin
            // A prescale lowered below pre_cnt lets the counter wrap before ticking again.
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable prescaled timer: one-shot/periodic terminal count with a tc pulse, commands take effect next cycle.
// cmd_ready drops only for the single ARM cycle; a held cmd_valid is accepted the cycle after.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   period_q, period_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic               periodic_q, periodic_d;

    logic               tick;
    logic               cmd_acc;
    logic               start_acc;
    logic               stop_acc;
    logic               load_per_acc;
    logic               load_pre_acc;
    logic               term_hit;
    logic               tc_fire;
    logic               pre_clear;
    logic               pre_enable;

    tick_prescaler #(
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (pre_clear),
        .enable   (pre_enable),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // Command decode and terminal-count detection.
    always_comb begin
        cmd_acc      = cmd_valid && cmd_ready;
        start_acc    = cmd_acc && (cmd_op == OP_START);
        stop_acc     = cmd_acc && (cmd_op == OP_STOP);
        load_per_acc = cmd_acc && (cmd_op == OP_LOAD_PERIOD);
        load_pre_acc = cmd_acc && (cmd_op == OP_LOAD_PRESCALE);
        term_hit     = (state_q == ST_RUN) && tick && (count_q >= period_q);
        // START/STOP landing on the terminal cycle swallow the event; LOADs do not.
        tc_fire      = term_hit && !start_acc && !stop_acc;
        pre_clear    = start_acc || (state_q == ST_ARM);
        pre_enable   = (state_q == ST_RUN);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
                if (start_acc) begin
                    state_d = ST_ARM;
                end else if (tc_fire && !periodic_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (start_acc) state_d = ST_ARM;
            default: state_d = ST_IDLE;
        endcase
        if (stop_acc) begin
            state_d = ST_IDLE;
        end
    end

    // Datapath: configuration registers and the clear/increment counter.
    always_comb begin
        period_d   = load_per_acc ? cmd_data : period_q;
        prescale_d = load_pre_acc ? cmd_data[PRE_W-1:0] : prescale_q;
        periodic_d = start_acc ? cmd_data[0] : periodic_q;
        count_d    = count_q;
        if (start_acc || (state_q == ST_ARM)) begin
            count_d = '0;
        end else if ((state_q == ST_RUN) && tick && !stop_acc) begin
            if (tc_fire) begin
                count_d = periodic_q ? '0 : count_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        cmd_ready = (state_q != ST_ARM);
        busy      = state_is_busy(state_q);
        done      = (state_q == ST_DONE);
        tc_pulse  = tc_fire;
        count     = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            period_q   <= '1;
            prescale_q <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            periodic_q <= periodic_d;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table for the main flows plus hand sequences for corner cases.
module tb_timer_ctrl;

    localparam logic [1:0] LP = 2'd0;
    localparam logic [1:0] LS = 2'd1;
    localparam logic [1:0] ST = 2'd2;
    localparam logic [1:0] SP = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] count;
    logic       busy;
    logic       tc_pulse;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       vld;
        logic [1:0] op;
        logic [7:0] dat;
        logic [7:0] e_cnt;
        logic       e_busy;
        logic       e_tc;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[$];

    timer_ctrl #(
        .WIDTH     (8),
        .PRE_W     (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] o, input logic [7:0] d,
                                input logic [7:0] c, input logic b, input logic t,
                                input logic dn, input logic r);
        vec_t x;
        x.vld = v; x.op = o; x.dat = d;
        x.e_cnt = c; x.e_busy = b; x.e_tc = t; x.e_done = dn; x.e_rdy = r;
        return x;
    endfunction

    // Offers one command, holding it until accepted; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] dat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = dat;
        for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
        chk("send_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_count(input logic [7:0] v);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (count == v && busy) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_count", {31'd0, hit}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Periodic P=3 S=0 from reset, then reconfigure in RUN and one-shot P=2 S=2.
        vecs.push_back(mk(0, LP, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, LP, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, LS, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, ST, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 3, 1, 1, 0, 1));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 3, 1, 1, 0, 1));
        vecs.push_back(mk(1, LP, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, LS, 2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, ST, 0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 1, 0, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 1, 1, 0, 1));
        vecs.push_back(mk(0, LP, 0, 2, 0, 0, 1, 1));
        vecs.push_back(mk(0, LP, 0, 2, 0, 0, 1, 1));

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_tc", {31'd0, tc_pulse}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            cmd_valid = vecs[i].vld;
            cmd_op    = vecs[i].op;
            cmd_data  = vecs[i].dat;
            #1;
            chk($sformatf("vec%0d_count", i), {24'd0, count}, {24'd0, vecs[i].e_cnt});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d_tc", i), {31'd0, tc_pulse}, {31'd0, vecs[i].e_tc});
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].e_done});
            chk($sformatf("vec%0d_ready", i), {31'd0, cmd_ready}, {31'd0, vecs[i].e_rdy});
        end
        @(negedge clk);
        cmd_valid = 1'b0;

        // Reset asserted mid-run aborts without a tc pulse.
        send(LP, 8'd3);
        send(LS, 8'd0);
        send(ST, 8'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_count", {24'd0, count}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_tc", {31'd0, tc_pulse}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // STOP accepted on the terminal cycle suppresses the pulse and holds count.
        send(LP, 8'd3);
        send(ST, 8'd1);
        wait_count(8'd3);
        cmd_valid = 1'b1;
        cmd_op    = SP;
        cmd_data  = 8'd0;
        #1;
        chk("stoptc_tc", {31'd0, tc_pulse}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("stoptc_busy", {31'd0, busy}, 32'd0);
        chk("stoptc_done", {31'd0, done}, 32'd0);
        chk("stoptc_count", {24'd0, count}, 32'd3);
        repeat (3) @(negedge clk);
        #1;
        chk("stoptc_hold", {24'd0, count}, 32'd3);
        chk("stoptc_tc_idle", {31'd0, tc_pulse}, 32'd0);

        // Period lowered below the running count fires on the next tick.
        send(LP, 8'd10);
        send(ST, 8'd1);
        wait_count(8'd7);
        cmd_valid = 1'b1;
        cmd_op    = LP;
        cmd_data  = 8'd4;
        #1;
        chk("lower_tc_at7", {31'd0, tc_pulse}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("lower_count8", {24'd0, count}, 32'd8);
        chk("lower_tc", {31'd0, tc_pulse}, 32'd1);
        @(negedge clk);
        #1;
        chk("lower_wrap", {24'd0, count}, 32'd0);
        chk("lower_tc_after", {31'd0, tc_pulse}, 32'd0);
        @(negedge clk);
        #1;
        chk("lower_count1", {24'd0, count}, 32'd1);

        // START then STOP held on cmd_valid: ready drops for the ARM cycle only.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ST;
        cmd_data  = 8'd1;
        #1;
        chk("arm_ready_pre", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_op    = SP;
        cmd_data  = 8'd0;
        #1;
        chk("arm_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("arm_busy", {31'd0, busy}, 32'd1);
        chk("arm_count", {24'd0, count}, 32'd0);
        @(negedge clk);
        #1;
        chk("arm_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("arm_run_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("arm_idle_busy", {31'd0, busy}, 32'd0);
        chk("arm_idle_done", {31'd0, done}, 32'd0);
        chk("arm_idle_count", {24'd0, count}, 32'd0);

        // Period zero: terminal event on every tick, count stays at zero.
        send(LP, 8'd0);
        send(ST, 8'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("p0_tc%0d", k), {31'd0, tc_pulse}, 32'd1);
            chk($sformatf("p0_count%0d", k), {24'd0, count}, 32'd0);
        end
        send(SP, 8'd0);
        #1;
        chk("p0_stopped", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
